// File: rtl/ccff_pkg.sv
// Shared types and per-tile chain lengths for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    DONE
  } ccff_ld_state_t;

  // 3x6 + 3x2 mux memory bits for connection blocks
  localparam int CBX_CHAIN_LEN = 24;
  localparam int CBY_CHAIN_LEN = 24;
  localparam int SB_CHAIN_LEN  = 32;

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in serial-out register; head_next is the bit the chain will see next cycle.
module ccff_piso #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] par_in,
  output logic              head_next
);

  logic [WORD_W-1:0] shreg_reg;
  logic [WORD_W-1:0] shreg_next;

  always_comb begin
    shreg_next = shreg_reg;
    if (load) begin
      shreg_next = par_in;
    end else if (shift) begin
      shreg_next = shreg_reg >> 1;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= shreg_next;
    end
  end

  assign head_next = shreg_next[0];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds bitstream words LSB-first into a configuration chain head, gating the chain
// clock for exactly CHAIN_LEN cycles per completed load.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = CBX_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int LEFT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

  ccff_ld_state_t    state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next, cnt_inc, remaining;
  logic [LEFT_W-1:0] word_left_reg, word_left_next, left_init;
  logic cfg_ready_reg, cfg_ready_next;
  logic ccff_head_reg, ccff_head_next;
  logic chain_en_reg, chain_en_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic aborted_reg, aborted_next;
  logic piso_load, piso_shift, head_next;

  ccff_piso #(.WORD_W(WORD_W)) u_piso (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .load     (piso_load),
    .shift    (piso_shift),
    .par_in   (cfg_data),
    .head_next(head_next)
  );

  assign cnt_inc   = bit_cnt_reg + CNT_W'(1);
  assign remaining = LAST_CNT - bit_cnt_reg;
  // The last word may be only partly needed; its upper bits are never shifted.
  assign left_init = (int'(remaining) < WORD_W) ? LEFT_W'(remaining) : LEFT_W'(WORD_W);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    word_left_next = word_left_reg;
    aborted_next   = aborted_reg;
    piso_load      = 1'b0;
    piso_shift     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && abort) begin
          aborted_next = 1'b1;
        end else if (start) begin
          state_next   = WAIT;
          bit_cnt_next = '0;
          aborted_next = 1'b0;
        end
      end
      WAIT: begin
        if (abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (cfg_valid && cfg_ready_reg) begin
          piso_load      = 1'b1;
          word_left_next = left_init;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else begin
          piso_shift     = 1'b1;
          bit_cnt_next   = cnt_inc;
          word_left_next = word_left_reg - LEFT_W'(1);
          if (cnt_inc == LAST_CNT) begin
            state_next = DONE;
          end else if (word_left_reg == LEFT_W'(1)) begin
            state_next = WAIT;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (abort) begin
          aborted_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    cfg_ready_next = (state_next == WAIT);
    chain_en_next  = (state_next == SHIFT);
    ccff_head_next = (state_next == SHIFT) && head_next;
    busy_next      = (state_next == WAIT) || (state_next == SHIFT);
    done_next      = (state_next == DONE);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      word_left_reg <= '0;
      cfg_ready_reg <= 1'b0;
      ccff_head_reg <= 1'b0;
      chain_en_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      word_left_reg <= word_left_next;
      cfg_ready_reg <= cfg_ready_next;
      ccff_head_reg <= ccff_head_next;
      chain_en_reg  <= chain_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign ccff_head = ccff_head_reg;
  assign chain_en  = chain_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;

endmodule
